// File: rtl/dout_capture_fifo.sv
// -----------------------------------------------------------------------------
// dout_capture_fifo
//
// Purpose:
//   Watches the CPU result port (Data_Out) and records only value changes.
//   Each change is written into a small FIFO and handed to a downstream
//   consumer over a valid/ready handshake, so a long-running program leaves
//   a compact trace of its results.
//
// Optional feature (compile-time macro CAPTURE_TS_EN):
//   When defined, a free-running TS_WIDTH-bit cycle counter is built. Its
//   value at the push edge is stored with each entry and presented on out_ts.
//   The counter starts from reset and is not affected by clear.
//   When undefined, no counter or timestamp storage exists and out_ts is 0.
//
// Parameters:
//   DATA_WIDTH - width of the sampled result and of each FIFO entry
//   DEPTH      - number of FIFO entries (power of two, >= 2)
//   TS_WIDTH   - timestamp width (only meaningful with CAPTURE_TS_EN)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   clear      in   synchronous flush of FIFO, change detector and overflow
//   en         in   capture enable; data_in is sampled only while high
//   data_in    in   CPU result being monitored
//   out_valid  out  head entry available
//   out_ready  in   consumer accepts the head entry
//   out_data   out  head entry value (0 while empty)
//   out_ts     out  head entry timestamp (0 while empty or without the macro)
//   count      out  number of stored entries, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  sticky; a change was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module dout_capture_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int TS_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [TS_WIDTH-1:0]      out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra MSB so that equal low bits with differing
    // MSBs means full, and fully equal pointers means empty.
    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic                    last_valid_q, last_valid_d;
    logic [DATA_WIDTH-1:0]   last_val_q;
    logic                    overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [AW:0]             count_w;
    logic                    full_w;
    logic                    empty_w;
    logic                    push_req;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic                    wr_en;

    // -------------------------------------------------------------------------
    // Occupancy and handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        count_w  = wr_ptr_q - rd_ptr_q;
        empty_w  = (count_w == '0);
        full_w   = (count_w == DEPTH_C);
        push_req = en && (!last_valid_q || (data_in != last_val_q));
        pop      = !empty_w && out_ready;
        // A pop on the same edge frees the slot the push needs.
        push     = push_req && (!full_w || pop);
        drop     = push_req && full_w && !pop;
        wr_en    = push && !clear;
    end

    // -------------------------------------------------------------------------
    // Next-state for control registers; clear overrides push and pop.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_valid_d = last_valid_q;
        overflow_d   = overflow_q;
        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            last_valid_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (en) begin
                last_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_valid_q <= last_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Data-path registers: no reset needed, qualified by last_valid / pointers.
    // A dropped value still updates last_val so it is never retried.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (en && !clear) begin
            last_val_q <= data_in;
        end
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign count     = count_w;
    assign full      = full_w;
    assign empty     = empty_w;
    assign out_valid = !empty_w;
    assign overflow  = overflow_q;
    assign out_data  = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];

`ifdef CAPTURE_TS_EN
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_mem_q [DEPTH];

    // Free-running; wraps naturally at 2^TS_WIDTH and ignores clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ts_mem_q[wr_ptr_q[AW-1:0]] <= ts_q;
        end
    end

    assign out_ts = empty_w ? '0 : ts_mem_q[rd_ptr_q[AW-1:0]];
`else
    assign out_ts = '0;
`endif

endmodule

// File: tb/tb_dout_capture_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for dout_capture_fifo. A queue-based reference model tracks the
// expected FIFO contents, change detector, overflow flag and timestamps.
// -----------------------------------------------------------------------------
module tb_dout_capture_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TSW   = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk;
    logic            rst;
    logic            clear;
    logic            en;
    logic [DW-1:0]   data_in;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [TSW-1:0]  out_ts;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0]   mdata[$];
    logic [TSW-1:0]  mts[$];
    logic            mlv;
    logic [DW-1:0]   mlval;
    logic            movf;
    logic [TSW-1:0]  mtsc;

    dout_capture_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .TS_WIDTH  (TSW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .en       (en),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ts   (out_ts),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        mdata.delete();
        mts.delete();
        mlv  = 1'b0;
        mlval = '0;
        movf = 1'b0;
        mtsc = '0;
    endfunction

    // One clock edge: drive inputs, advance the model, settle past the edge.
    task automatic cycle(input logic e, input logic [DW-1:0] d, input logic r, input logic c);
        bit do_pop;
        bit req;
        en = e; data_in = d; out_ready = r; clear = c;
        @(posedge clk);
        if (c) begin
            mdata.delete();
            mts.delete();
            mlv  = 1'b0;
            movf = 1'b0;
        end else begin
            do_pop = (mdata.size() > 0) && r;
            req    = e && (!mlv || d != mlval);
            if (do_pop) begin
                void'(mdata.pop_front());
                void'(mts.pop_front());
            end
            if (req) begin
                if (mdata.size() < DEPTH) begin
                    mdata.push_back(d);
                    mts.push_back(mtsc);
                end else begin
                    movf = 1'b1;
                end
            end
            if (e) begin
                mlv   = 1'b1;
                mlval = d;
            end
        end
        mtsc = mtsc + TSW'(1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clear = 1'b0; out_ready = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== '0)   begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)  begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_ts !== '0)   begin errors++; $display("FAIL reset_ts got=%h exp=0", out_ts); end
    endtask

    task automatic test_hold_value();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'd5, 1'b0, 1'b0);
            if (i == 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_first got=%b exp=1", out_valid); end
                checks++; if (out_data !== 32'd5) begin errors++; $display("FAIL hold_data_first got=%0d exp=5", out_data); end
            end
        end
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL hold_count got=%0d exp=1", count); end
        checks++; if (out_data !== 32'd5) begin errors++; $display("FAIL hold_data got=%0d exp=5", out_data); end
        cycle(1'b0, 32'd0, 1'b1, 1'b0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hold_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_dedup();
        logic [DW-1:0] seq [7];
        seq = '{32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd3, 32'd4};
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        foreach (seq[i]) cycle(1'b1, seq[i], 1'b0, 1'b0);
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL dedup_count got=%0d exp=4", count); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_data !== DW'(i)) begin errors++; $display("FAIL dedup_order got=%0d exp=%0d", out_data, i); end
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL dedup_empty got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 7) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_at8 got=%b exp=1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", overflow); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_data !== DW'(i)) begin errors++; $display("FAIL ovf_drain got=%0d exp=%0d", out_data, i); end
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_push_pop();
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h10 + DW'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full got=%b exp=1", full); end
        cycle(1'b1, 32'hAA, 1'b1, 1'b0);
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fpp_count got=%0d exp=%0d", count, DEPTH); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got=%b exp=0", overflow); end
        checks++; if (out_data !== 32'h11) begin errors++; $display("FAIL fpp_head got=%h exp=11", out_data); end
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] exp;
            exp = (i == DEPTH-1) ? 32'hAA : 32'h11 + DW'(i);
            checks++; if (out_data !== exp) begin errors++; $display("FAIL fpp_drain got=%h exp=%h", out_data, exp); end
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_clear();
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'd20 + DW'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'd7, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_overflow got=%b exp=1", overflow); end
        cycle(1'b1, 32'd7, 1'b1, 1'b1);
        checks++; if (count !== '0) begin errors++; $display("FAIL clr_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", out_valid); end
        cycle(1'b1, 32'd7, 1'b0, 1'b0);
        checks++; if (count !== CW'(1)) begin errors++; $display("FAIL clr_recapture_count got=%0d exp=1", count); end
        checks++; if (out_data !== 32'd7) begin errors++; $display("FAIL clr_recapture_data got=%0d exp=7", out_data); end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd100 + DW'(i), 1'b0, 1'b0);
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL arst_pre_count got=%0d exp=3", count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== '0) begin errors++; $display("FAIL arst_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL arst_data got=%h exp=0", out_data); end
        en = 1'b0; clear = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_timestamp();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 3; i < 10; i++) cycle(1'b1, 32'h55, 1'b0, 1'b0);
        cycle(1'b1, 32'h66, 1'b0, 1'b0);
        checks++; if (count !== CW'(2)) begin errors++; $display("FAIL ts_count got=%0d exp=2", count); end
`ifdef CAPTURE_TS_EN
        checks++; if (out_ts !== TSW'(3)) begin errors++; $display("FAIL ts_first got=%0d exp=3", out_ts); end
        cycle(1'b1, 32'h66, 1'b1, 1'b0);
        checks++; if (out_ts !== TSW'(10)) begin errors++; $display("FAIL ts_second got=%0d exp=10", out_ts); end
`else
        checks++; if (out_ts !== '0) begin errors++; $display("FAIL ts_first got=%0d exp=0", out_ts); end
        cycle(1'b1, 32'h66, 1'b1, 1'b0);
        checks++; if (out_ts !== '0) begin errors++; $display("FAIL ts_second got=%0d exp=0", out_ts); end
`endif
        checks++; if (out_data !== 32'h66) begin errors++; $display("FAIL ts_second_data got=%h exp=66", out_data); end
    endtask

    task automatic test_random();
        logic            e, r, c;
        logic [DW-1:0]   d;
        logic [DW-1:0]   exp_data;
        logic [TSW-1:0]  exp_ts;
        for (int n = 0; n < 600; n++) begin
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 49) == 0);
            d = DW'($urandom_range(0, 3));
            if (($urandom_range(0, 9)) == 0) d = $urandom;
            cycle(e, d, r, c);
            exp_data = (mdata.size() > 0) ? mdata[0] : '0;
`ifdef CAPTURE_TS_EN
            exp_ts = (mts.size() > 0) ? mts[0] : '0;
`else
            exp_ts = '0;
`endif
            checks++; if (count !== CW'(mdata.size())) begin errors++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, mdata.size()); end
            checks++; if (out_valid !== (mdata.size() > 0)) begin errors++; $display("FAIL rnd_valid n=%0d got=%b", n, out_valid); end
            checks++; if (full !== (mdata.size() == DEPTH)) begin errors++; $display("FAIL rnd_full n=%0d got=%b", n, full); end
            checks++; if (empty !== (mdata.size() == 0)) begin errors++; $display("FAIL rnd_empty n=%0d got=%b", n, empty); end
            checks++; if (overflow !== movf) begin errors++; $display("FAIL rnd_overflow n=%0d got=%b exp=%b", n, overflow, movf); end
            checks++; if (out_data !== exp_data) begin errors++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, out_data, exp_data); end
            checks++; if (out_ts !== exp_ts) begin errors++; $display("FAIL rnd_ts n=%0d got=%h exp=%h", n, out_ts, exp_ts); end
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; en = 1'b0; out_ready = 1'b0; data_in = '0;
        model_reset();
        test_reset();
        test_hold_value();
        test_dedup();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_async_reset();
        test_timestamp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dout_capture_fifo.md
Name: dout_capture_fifo

Overview:
Downstream consumer of the CPU's Data_Out result port. It samples the 32-bit result each cycle and pushes a new entry only when the value changes. Entries are held in a small FIFO and drained over a valid/ready interface to the bench or display driver. Only value changes are recorded, so long-running programs produce a compact trace.

Parameters:
DATA_WIDTH, 32, width of sampled result and of each FIFO entry
DEPTH, 8, FIFO entries; power of two, minimum 2
TS_WIDTH, 16, timestamp width; used only when CAPTURE_TS_EN is defined

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush of FIFO, change detector and overflow flag
en  input  1  capture enable; data_in is sampled only while high
data_in  input  DATA_WIDTH  CPU result (Data_Out)
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_data  output  DATA_WIDTH  head entry value
out_ts  output  TS_WIDTH  head entry timestamp; constant 0 without CAPTURE_TS_EN
count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky; set when a change is dropped because the FIFO is full

Behaviour:
- Reset (async, rst=1):
  - count=0, empty=1, full=0, out_valid=0, overflow=0.
  - Read and write pointers = 0; last_valid=0; timestamp counter = 0.
  - out_data and out_ts read as 0 while empty.
- Change detector:
  - Registers last_val and last_valid.
  - push_req = en && (!last_valid || data_in != last_val).
  - When en=1 at a rising edge: last_val <= data_in, last_valid <= 1.
  - When en=0: detector holds its state; no push.
- Push:
  - When push_req and the FIFO is not full (or a pop happens the same edge), data_in is written at wr_ptr and wr_ptr increments.
  - Pointers wrap modulo DEPTH using an extra MSB for full/empty discrimination.
- Pop:
  - Occurs when out_valid && out_ready at the edge; rd_ptr increments.
- Outputs:
  - out_valid = !empty, registered-state derived; no fall-through.
  - out_data/out_ts = storage[rd_ptr], combinational from registered storage.
- Latency: a change sampled at edge N is visible on out_valid/out_data in cycle N+1; there is no same-cycle bypass.
- Simultaneous push and pop:
  - Not full: both occur; count unchanged.
  - Full: pop frees a slot, push is accepted, count stays DEPTH, overflow is not set.
  - Empty: no pop is possible (out_valid=0); push only.
- Full with push_req and no pop: the entry is dropped, overflow <= 1, and last_val still updates. A dropped value is never retried.
- overflow clears only on rst or clear.
- clear=1 at an edge:
  - count=0, pointers=0, overflow=0, last_valid=0.
  - Overrides push and pop in the same cycle.
  - The next enabled sample is captured unconditionally.
- Reset mid-operation: all entries are discarded immediately (async); no partial output is emitted.
- out_ready while empty is ignored; out_data is not required to hold once popped.

Optional Feature:
CAPTURE_TS_EN defined:
- A free-running TS_WIDTH cycle counter runs from reset and wraps 2^TS_WIDTH-1 -> 0.
- clear does not reset it.
- Its value at the push edge is stored with each entry and presented on out_ts alongside out_data.
Undefined:
- No counter or timestamp storage is built.
- out_ts is tied to 0.
- All other behaviour is identical.

Test Plan:
1. Reset, en=1, data_in held at 5 for 10 cycles -> exactly one entry; out_valid high from cycle after first edge; out_data=5; count=1.
2. en=1, out_ready=0; data_in sequence 1,2,2,3,3,3,4 -> count=4; draining with out_ready=1 yields 1,2,3,4 in order, then empty=1.
3. DEPTH=8, out_ready=0, feed 10 distinct values 0..9 -> full=1 after 8 entries; overflow=1; drain yields 0..7 only.
4. FIFO full, same edge: out_ready=1 and new value 0xAA -> head popped, 0xAA accepted as tail, count stays 8, overflow stays 0.
5. Sequence 7, clear pulse, 7 again -> after clear: count=0, overflow=0; the second 7 is captured (count=1, out_data=7). Assert rst mid-stream with 3 entries -> count=0 and out_valid=0 asynchronously.
6. With CAPTURE_TS_EN: reset, changes at cycles 3 and 10 -> out_ts reads 3 then 10. Without the macro: out_ts=0 for all entries.
